// File: rtl/blnk_pkg.sv
// Shared types and constants for the blank-encoded display timing source.
package blnk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HBLANK = 2'd3
    } blnk_state_t;

    // Receiver decodes any low interval of at least VSYNC_MIN_BLANK cycles as vsync
    localparam int unsigned VSYNC_MIN_BLANK = 2052;
    localparam int unsigned HSYNC_MAX_BLANK = 2048;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned PIX_W  = 12;
    localparam int unsigned LINE_W = 12;
    localparam int unsigned VB_W   = 16;
    localparam int unsigned FCNT_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/blnk_lfsr.sv
// Compare-stream LFSR: seed load has priority over advance.
module blnk_lfsr
    import blnk_pkg::*;
(
    input  logic              pixclk,
    input  logic              reset,
    input  logic              load,
    input  logic              adv,
    output logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_nxt_c
);

    always_comb begin
        state_nxt_c = state;
        if (load) begin
            state_nxt_c = LFSR_SEED;
        end else if (adv) begin
            state_nxt_c = lfsr_step(state);
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= state_nxt_c;
        end
    end

endmodule

// File: rtl/blnk_gen.sv
// Blank-encoded sync source: blankx timing, LFSR compare stream and MISR capture request.
module blnk_gen
    import blnk_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 4096
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              misr_req,
    output logic              blankx,
    output logic              red_comp,
    output logic              grn_comp,
    output logic              blu_comp,
    output logic              misr_cntl,
    output logic              misr_pend,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned HA_BITS = $clog2(H_ACTIVE + 1);
    localparam int unsigned HB_BITS = $clog2(H_BLANK + 1);
    localparam int unsigned VA_BITS = $clog2(V_ACTIVE + 1);
    localparam int unsigned VB_BITS = $clog2(V_BLANK + 1);

    if (H_ACTIVE < 1 || H_ACTIVE > 4095 || HA_BITS > PIX_W) begin : g_bad_h_active
        $error("blnk_gen: H_ACTIVE out of range 1..4095");
    end
    if (H_BLANK < 1 || H_BLANK > int'(HSYNC_MAX_BLANK) || HB_BITS > PIX_W) begin : g_bad_h_blank
        $error("blnk_gen: H_BLANK out of range 1..2048");
    end
    if (V_ACTIVE < 1 || V_ACTIVE > 4095 || VA_BITS > LINE_W) begin : g_bad_v_active
        $error("blnk_gen: V_ACTIVE out of range 1..4095");
    end
    if (V_BLANK < int'(VSYNC_MIN_BLANK) || V_BLANK > 65535 || VB_BITS > VB_W) begin : g_bad_v_blank
        $error("blnk_gen: V_BLANK out of range 2052..65535");
    end

    localparam logic [PIX_W-1:0]  HA_LAST = PIX_W'(H_ACTIVE - 1);
    localparam logic [PIX_W-1:0]  HB_LAST = PIX_W'(H_BLANK - 1);
    localparam logic [LINE_W-1:0] VA_LAST = LINE_W'(V_ACTIVE - 1);
    localparam logic [VB_W-1:0]   VB_LAST = VB_W'(V_BLANK - 1);

    blnk_state_t       state_q, state_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [VB_W-1:0]   vb_q, vb_d;

    logic              vb_entry;
    logic              last_px;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_nxt;

    logic              blankx_d;
    logic [2:0]        comp_d;
    logic              misr_cntl_d;
    logic              misr_pend_d;
    logic [FCNT_W-1:0] frame_cnt_d;

    logic unused_lfsr;
    assign unused_lfsr = ^{lfsr_q, lfsr_nxt[LFSR_W-1:3]};

    blnk_lfsr u_lfsr (
        .pixclk      (pixclk),
        .reset       (reset),
        .load        (vb_entry),
        .adv         (lfsr_adv),
        .state       (lfsr_q),
        .state_nxt_c (lfsr_nxt)
    );

    // Next-state, counters and next registered outputs
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        line_d      = line_q;
        vb_d        = vb_q;
        vb_entry    = 1'b0;
        last_px     = 1'b0;
        lfsr_adv    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_VBLANK;
                    vb_d     = '0;
                    vb_entry = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (vb_q == VB_LAST) begin
                    state_d = ST_ACTIVE;
                    pix_d   = '0;
                    line_d  = '0;
                end else begin
                    vb_d = vb_q + VB_W'(1);
                end
            end
            ST_ACTIVE: begin
                lfsr_adv = 1'b1;
                if (pix_q == HA_LAST) begin
                    pix_d = '0;
                    if (line_q == VA_LAST) begin
                        // Frame boundary: the last line carries no HBLANK
                        last_px = 1'b1;
                        if (enable) begin
                            state_d  = ST_VBLANK;
                            vb_d     = '0;
                            vb_entry = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HBLANK;
                    end
                end else begin
                    pix_d = pix_q + PIX_W'(1);
                end
            end
            ST_HBLANK: begin
                if (pix_q == HB_LAST) begin
                    pix_d   = '0;
                    line_d  = line_q + LINE_W'(1);
                    state_d = ST_ACTIVE;
                end else begin
                    pix_d = pix_q + PIX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        blankx_d = (state_d == ST_ACTIVE);
        comp_d   = blankx_d ? {lfsr_nxt[0], lfsr_nxt[1], lfsr_nxt[2]} : 3'b000;

        // A request coinciding with VBLANK entry is held for the following frame
        misr_cntl_d = misr_cntl;
        misr_pend_d = misr_pend;
        if (vb_entry) begin
            misr_cntl_d = misr_pend;
            misr_pend_d = misr_req && !misr_pend;
        end else if (misr_req && !misr_cntl) begin
            misr_pend_d = 1'b1;
        end

        frame_cnt_d = frame_cnt + FCNT_W'(last_px);
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pix_q      <= '0;
            line_q     <= '0;
            vb_q       <= '0;
            blankx     <= 1'b0;
            red_comp   <= 1'b0;
            grn_comp   <= 1'b0;
            blu_comp   <= 1'b0;
            misr_cntl  <= 1'b0;
            misr_pend  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            vb_q       <= vb_d;
            blankx     <= blankx_d;
            red_comp   <= comp_d[2];
            grn_comp   <= comp_d[1];
            blu_comp   <= comp_d[0];
            misr_cntl  <= misr_cntl_d;
            misr_pend  <= misr_pend_d;
            frame_done <= last_px;
            frame_cnt  <= frame_cnt_d;
        end
    end

endmodule
